// File: rtl/fetch_stage.sv
// Instruction fetch stage and IF/ID register for a 5-stage RV32I pipeline.
// Optional sticky misaligned-target trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pc_en,
  input  logic        i_if_id_en,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_target,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic        i_imem_valid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_if_id_pc,
  output logic [31:0] o_if_id_pc_plus4,
  output logic [31:0] o_if_id_inst,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic        o_fetch_misaligned,
`endif
  output logic        o_if_id_valid
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic        kill_reg, kill_next;
  logic [31:0] buf_reg, buf_next;
  logic [31:0] if_id_pc_reg, if_id_pc_next;
  logic [31:0] if_id_pc_plus4_reg, if_id_pc_plus4_next;
  logic [31:0] if_id_inst_reg, if_id_inst_next;
  logic        if_id_valid_reg, if_id_valid_next;

  logic        advance;
  logic        load_fetch;
  logic        load_buf;
  logic        trap_hit;
  logic        locked;
  logic [31:0] redirect_pc;
  logic [31:0] pc_plus4;

  assign advance  = i_pc_en & i_if_id_en;
  assign pc_plus4 = pc_reg + 32'd4;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned_reg;

  assign trap_hit    = i_redirect && (i_redirect_target[1:0] != 2'b00);
  assign redirect_pc = i_redirect_target;
  assign locked      = misaligned_reg;

  // Sticky until reset: once set, fetching stops for good.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      misaligned_reg <= 1'b0;
    end else if (trap_hit) begin
      misaligned_reg <= 1'b1;
    end
  end

  assign o_fetch_misaligned = misaligned_reg;
`else
  logic unused_target_lsbs;

  assign unused_target_lsbs = ^i_redirect_target[1:0];
  assign trap_hit           = 1'b0;
  assign locked             = 1'b0;
  assign redirect_pc        = {i_redirect_target[31:2], 2'b00};
`endif

  always_comb begin
    state_next          = state_reg;
    pc_next             = pc_reg;
    kill_next           = kill_reg;
    buf_next            = buf_reg;
    if_id_pc_next       = if_id_pc_reg;
    if_id_pc_plus4_next = if_id_pc_plus4_reg;
    if_id_inst_next     = if_id_inst_reg;
    if_id_valid_next    = if_id_valid_reg;
    load_fetch          = 1'b0;
    load_buf            = 1'b0;
    o_imem_req          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!locked) begin
          state_next = REQ;
        end
      end
      REQ: begin
        o_imem_req = 1'b1;
        if (i_imem_ready) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (i_imem_valid) begin
          if (kill_reg) begin
            kill_next  = 1'b0;
            state_next = REQ;
          end else if (advance) begin
            load_fetch = 1'b1;
            pc_next    = pc_plus4;
            state_next = REQ;
          end else begin
            buf_next   = i_imem_rdata;
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (advance) begin
          load_buf   = 1'b1;
          pc_next    = pc_plus4;
          state_next = REQ;
        end
      end
      default: state_next = IDLE;
    endcase

    if (load_fetch || load_buf) begin
      if_id_pc_next       = pc_reg;
      if_id_pc_plus4_next = pc_plus4;
      if_id_inst_next     = load_fetch ? i_imem_rdata : buf_reg;
      if_id_valid_next    = 1'b1;
    end else if (i_if_id_en) begin
      if_id_inst_next  = NOP_INST;
      if_id_valid_next = 1'b0;
    end

    // Redirect outranks stalls and responses; the in-flight fetch becomes wrong-path.
    if (i_redirect) begin
      pc_next             = redirect_pc;
      if_id_pc_next       = if_id_pc_reg;
      if_id_pc_plus4_next = if_id_pc_plus4_reg;
      if_id_inst_next     = NOP_INST;
      if_id_valid_next    = 1'b0;
      case (state_reg)
        REQ: begin
          if (i_imem_ready) begin
            kill_next  = 1'b1;
            state_next = WAIT;
          end else begin
            state_next = REQ;
          end
        end
        WAIT: begin
          if (i_imem_valid) begin
            kill_next  = 1'b0;
            state_next = REQ;
          end else begin
            kill_next  = 1'b1;
            state_next = WAIT;
          end
        end
        default: state_next = REQ;
      endcase
      if (trap_hit || locked) begin
        state_next = IDLE;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg          <= IDLE;
      pc_reg             <= RESET_ADDR;
      kill_reg           <= 1'b0;
      buf_reg            <= NOP_INST;
      if_id_pc_reg       <= 32'h0;
      if_id_pc_plus4_reg <= 32'h0;
      if_id_inst_reg     <= NOP_INST;
      if_id_valid_reg    <= 1'b0;
    end else begin
      state_reg          <= state_next;
      pc_reg             <= pc_next;
      kill_reg           <= kill_next;
      buf_reg            <= buf_next;
      if_id_pc_reg       <= if_id_pc_next;
      if_id_pc_plus4_reg <= if_id_pc_plus4_next;
      if_id_inst_reg     <= if_id_inst_next;
      if_id_valid_reg    <= if_id_valid_next;
    end
  end

  assign o_imem_addr      = pc_reg;
  assign o_if_id_pc       = if_id_pc_reg;
  assign o_if_id_pc_plus4 = if_id_pc_plus4_reg;
  assign o_if_id_inst     = if_id_inst_reg;
  assign o_if_id_valid    = if_id_valid_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run
// checked against a program-order scoreboard and an address-hashed memory.
module tb_fetch_stage;
  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_pc_en;
  logic        i_if_id_en;
  logic        i_redirect;
  logic [31:0] i_redirect_target;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ready;
  logic        i_imem_valid;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_if_id_pc;
  logic [31:0] o_if_id_pc_plus4;
  logic [31:0] o_if_id_inst;
  logic        o_if_id_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        o_fetch_misaligned;
`endif

  always #5 i_clk = ~i_clk;

  fetch_stage #(.RESET_ADDR(RESET_ADDR), .NOP_INST(NOP_INST)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_pc_en(i_pc_en), .i_if_id_en(i_if_id_en),
    .i_redirect(i_redirect), .i_redirect_target(i_redirect_target),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_ready(i_imem_ready), .i_imem_valid(i_imem_valid), .i_imem_rdata(i_imem_rdata),
    .o_if_id_pc(o_if_id_pc), .o_if_id_pc_plus4(o_if_id_pc_plus4),
    .o_if_id_inst(o_if_id_inst),
`ifdef FETCH_MISALIGN_TRAP_EN
    .o_fetch_misaligned(o_fetch_misaligned),
`endif
    .o_if_id_valid(o_if_id_valid)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Memory model: one outstanding request, response after a drawn latency.
  int          ready_mode = 0;   // 0 always ready, 1 never, 2 random
  int          ready_pct  = 100;
  int          lat_min    = 0;
  int          lat_max    = 0;
  bit          mem_busy   = 1'b0;
  logic [31:0] mem_addr;
  int          mem_cnt;
  logic [31:0] mem_ovr [logic [31:0]];

  logic        pre_rst, pre_redirect, pre_pc_en, pre_if_id_en;
  logic        pre_req, pre_ready, pre_valid;
  logic [31:0] pre_target, pre_addr, pre_if_id_pc, pre_if_id_plus4, pre_if_id_inst;
  logic        pre_if_id_valid;
  logic [31:0] exp_next_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0003;
  endfunction

  task automatic tick();
    @(negedge i_clk);
    i_imem_valid = 1'b0;
    i_imem_rdata = $urandom;
    if (mem_busy && mem_cnt == 0) begin
      i_imem_valid = 1'b1;
      i_imem_rdata = mem_word(mem_addr);
    end
    case (ready_mode)
      0:       i_imem_ready = 1'b1;
      1:       i_imem_ready = 1'b0;
      default: i_imem_ready = ($urandom_range(99) < ready_pct);
    endcase
    pre_rst = i_rst;  pre_redirect = i_redirect;  pre_target = i_redirect_target;
    pre_pc_en = i_pc_en;  pre_if_id_en = i_if_id_en;
    pre_req = o_imem_req;  pre_addr = o_imem_addr;
    pre_ready = i_imem_ready;  pre_valid = i_imem_valid;
    pre_if_id_pc = o_if_id_pc;  pre_if_id_plus4 = o_if_id_pc_plus4;
    pre_if_id_inst = o_if_id_inst;  pre_if_id_valid = o_if_id_valid;
    @(posedge i_clk);
    #1;
    if (pre_rst) begin
      mem_busy = 1'b0;
    end else if (pre_req && pre_ready) begin
      mem_busy = 1'b1;
      mem_addr = pre_addr;
      mem_cnt  = int'($urandom_range(lat_max, lat_min));
    end else if (mem_busy && pre_valid) begin
      mem_busy = 1'b0;
    end else if (mem_busy && mem_cnt > 0) begin
      mem_cnt--;
    end
    if (!pre_rst && !pre_redirect && pre_if_id_en && o_if_id_valid)
      $display("[TB] t=%0t if_id load pc=%h inst=%h", $time, o_if_id_pc, o_if_id_inst);
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (o_if_id_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1;  i_redirect = 1'b0;  i_pc_en = 1'b1;  i_if_id_en = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
    exp_next_pc = RESET_ADDR;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;  i_redirect = 1'b0;  i_pc_en = 1'b1;  i_if_id_en = 1'b1;
    tick();
    tick();
    n_tests++;
    if (o_imem_req !== 1'b0 || o_imem_addr !== RESET_ADDR || o_if_id_pc !== 32'h0 ||
        o_if_id_pc_plus4 !== 32'h0 || o_if_id_inst !== NOP_INST || o_if_id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got req=%b addr=%h pc=%h p4=%h inst=%h v=%b, expected 0 %h 0 0 %h 0",
               o_imem_req, o_imem_addr, o_if_id_pc, o_if_id_pc_plus4, o_if_id_inst, o_if_id_valid,
               RESET_ADDR, NOP_INST);
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    n_tests++;
    if (o_fetch_misaligned !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_misaligned: got %b expected 0", o_fetch_misaligned);
    end
`endif
    i_rst = 1'b0;
  endtask

  task automatic test_zero_wait();
    ready_mode = 0;  lat_min = 0;  lat_max = 0;
    tick();
    n_tests++;
    if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL zw_first_req: got req=%b addr=%h expected 1 00000000", o_imem_req, o_imem_addr);
    end
    tick();
    tick();
    n_tests++;
    if (o_if_id_valid !== 1'b1 || o_if_id_pc !== 32'h0 || o_if_id_inst !== 32'h0050_0093 ||
        o_if_id_pc_plus4 !== 32'h4 || o_imem_req !== 1'b1 || o_imem_addr !== 32'h4) begin
      n_fail++;
      $display("FAIL zw_first_load: got v=%b pc=%h inst=%h p4=%h req=%b addr=%h expected 1 0 00500093 4 1 4",
               o_if_id_valid, o_if_id_pc, o_if_id_inst, o_if_id_pc_plus4, o_imem_req, o_imem_addr);
    end
    tick();
    n_tests++;
    if (o_if_id_valid !== 1'b0 || o_if_id_inst !== NOP_INST || o_imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL zw_bubble: got v=%b inst=%h req=%b expected 0 %h 0",
               o_if_id_valid, o_if_id_inst, o_imem_req, NOP_INST);
    end
    tick();
    n_tests++;
    if (o_if_id_valid !== 1'b1 || o_if_id_pc !== 32'h4 || o_if_id_inst !== 32'h00a0_0113 ||
        o_if_id_pc_plus4 !== 32'h8 || o_imem_addr !== 32'h8) begin
      n_fail++;
      $display("FAIL zw_second_load: got v=%b pc=%h inst=%h p4=%h addr=%h expected 1 4 00a00113 8 8",
               o_if_id_valid, o_if_id_pc, o_if_id_inst, o_if_id_pc_plus4, o_imem_addr);
    end
  endtask

  task automatic test_ready_stall();
    ready_mode = 1;
    for (int k = 0; k < 3; k++) begin
      i_if_id_en = (k != 0);
      tick();
      n_tests++;
      if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h8 || o_if_id_pc !== 32'h4 ||
          o_if_id_valid !== (k == 0)) begin
        n_fail++;
        $display("FAIL ready_stall[%0d]: got req=%b addr=%h pc=%h v=%b expected 1 8 4 %0d",
                 k, o_imem_req, o_imem_addr, o_if_id_pc, o_if_id_valid, (k == 0));
      end
    end
    i_if_id_en = 1'b1;
    ready_mode = 0;
  endtask

  task automatic test_hold();
    tick();
    i_pc_en = 1'b0;  i_if_id_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_tests++;
      if (o_imem_req !== 1'b0 || o_imem_addr !== 32'h8 || o_if_id_pc !== 32'h4 ||
          o_if_id_valid !== 1'b0 || o_if_id_inst !== NOP_INST) begin
        n_fail++;
        $display("FAIL hold_stall[%0d]: got req=%b addr=%h pc=%h v=%b inst=%h expected 0 8 4 0 %h",
                 k, o_imem_req, o_imem_addr, o_if_id_pc, o_if_id_valid, o_if_id_inst, NOP_INST);
      end
    end
    i_pc_en = 1'b1;  i_if_id_en = 1'b1;
    tick();
    n_tests++;
    if (o_if_id_valid !== 1'b1 || o_if_id_pc !== 32'h8 || o_if_id_inst !== 32'h0000_0033 ||
        o_if_id_pc_plus4 !== 32'hC || o_imem_req !== 1'b1 || o_imem_addr !== 32'hC) begin
      n_fail++;
      $display("FAIL hold_release: got v=%b pc=%h inst=%h p4=%h req=%b addr=%h expected 1 8 00000033 c 1 c",
               o_if_id_valid, o_if_id_pc, o_if_id_inst, o_if_id_pc_plus4, o_imem_req, o_imem_addr);
    end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    bit got_req;
    lat_min = 2;  lat_max = 2;
    tick();
    lat_min = 0;  lat_max = 0;
    i_redirect = 1'b1;  i_redirect_target = 32'h100;
    tick();
    i_redirect = 1'b0;
    n_tests++;
    if (o_if_id_valid !== 1'b0 || o_if_id_inst !== NOP_INST || o_imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rw_flush: got v=%b inst=%h req=%b expected 0 %h 0",
               o_if_id_valid, o_if_id_inst, o_imem_req, NOP_INST);
    end
    got_req = 1'b0;
    for (int i = 0; i < 10 && !got_req; i++) begin
      tick();
      n_tests++;
      if (o_if_id_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rw_late_drop: got v=%b inst=%h expected v=0", o_if_id_valid, o_if_id_inst);
      end
      got_req = (o_imem_req === 1'b1);
    end
    n_tests++;
    if (!got_req || o_imem_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL rw_target_req: got req=%b addr=%h expected 1 00000100", o_imem_req, o_imem_addr);
    end
    wait_valid(ok);
    n_tests++;
    if (!ok || o_if_id_pc !== 32'h100 || o_if_id_inst !== mem_word(32'h100)) begin
      n_fail++;
      $display("FAIL rw_first_valid: got ok=%b pc=%h inst=%h expected 1 00000100 %h",
               ok, o_if_id_pc, o_if_id_inst, mem_word(32'h100));
    end
  endtask

  task automatic test_redirect_flush();
    bit ok;
    i_if_id_en = 1'b0;
    tick();
    n_tests++;
    if (o_imem_req !== 1'b0 || o_if_id_valid !== 1'b1 || o_if_id_pc !== 32'h100) begin
      n_fail++;
      $display("FAIL rf_pre_hold: got req=%b v=%b pc=%h expected 0 1 00000100",
               o_imem_req, o_if_id_valid, o_if_id_pc);
    end
    i_redirect = 1'b1;  i_redirect_target = 32'h40;
    tick();
    i_redirect = 1'b0;  i_if_id_en = 1'b1;
    n_tests++;
    if (o_if_id_valid !== 1'b0 || o_if_id_inst !== NOP_INST || o_imem_req !== 1'b1 ||
        o_imem_addr !== 32'h40) begin
      n_fail++;
      $display("FAIL rf_flush_wins: got v=%b inst=%h req=%b addr=%h expected 0 %h 1 00000040",
               o_if_id_valid, o_if_id_inst, o_imem_req, o_imem_addr, NOP_INST);
    end
    wait_valid(ok);
    n_tests++;
    if (!ok || o_if_id_pc !== 32'h40 || o_if_id_inst !== mem_word(32'h40)) begin
      n_fail++;
      $display("FAIL rf_next_valid: got ok=%b pc=%h inst=%h expected 1 00000040 %h",
               ok, o_if_id_pc, o_if_id_inst, mem_word(32'h40));
    end
  endtask

  task automatic test_wrap();
    bit ok;
    ready_mode = 1;
    i_redirect = 1'b1;  i_redirect_target = 32'hFFFF_FFFC;
    tick();
    i_redirect = 1'b0;
    n_tests++;
    if (o_imem_req !== 1'b1 || o_imem_addr !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_req: got req=%b addr=%h expected 1 fffffffc", o_imem_req, o_imem_addr);
    end
    ready_mode = 0;
    wait_valid(ok);
    n_tests++;
    if (!ok || o_if_id_pc !== 32'hFFFF_FFFC || o_if_id_pc_plus4 !== 32'h0 ||
        o_if_id_inst !== mem_word(32'hFFFF_FFFC) || o_imem_addr !== 32'h0 || o_imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_load: got ok=%b pc=%h p4=%h inst=%h req=%b addr=%h expected 1 fffffffc 0 %h 1 0",
               ok, o_if_id_pc, o_if_id_pc_plus4, o_if_id_inst, o_imem_req, o_imem_addr,
               mem_word(32'hFFFF_FFFC));
    end
  endtask

  task automatic test_misalign();
    bit ok;
    ready_mode = 1;
    i_redirect = 1'b1;  i_redirect_target = 32'h102;
    tick();
    i_redirect = 1'b0;
    ready_mode = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if (o_fetch_misaligned !== 1'b1 || o_imem_req !== 1'b0 || o_if_id_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL misalign_trap[%0d]: got mis=%b req=%b v=%b expected 1 0 0",
                 k, o_fetch_misaligned, o_imem_req, o_if_id_valid);
      end
      tick();
    end
    do_reset();
    n_tests++;
    if (o_fetch_misaligned !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_clear: got %b expected 0", o_fetch_misaligned);
    end
`else
    n_tests++;
    if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL misalign_forced: got req=%b addr=%h expected 1 00000100", o_imem_req, o_imem_addr);
    end
    wait_valid(ok);
    n_tests++;
    if (!ok || o_if_id_pc !== 32'h100 || o_if_id_inst !== mem_word(32'h100)) begin
      n_fail++;
      $display("FAIL misalign_load: got ok=%b pc=%h inst=%h expected 1 00000100 %h",
               ok, o_if_id_pc, o_if_id_inst, mem_word(32'h100));
    end
`endif
  endtask

  task automatic test_random();
    int loads = 0;
    do_reset();
    ready_mode = 2;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 500 == 0) begin
        ready_pct = int'($urandom_range(100, 30));
        lat_max   = int'($urandom_range(3, 0));
        lat_min   = 0;
      end
      i_rst             = ($urandom_range(999) < 3);
      i_redirect        = ($urandom_range(99) < 6);
      i_redirect_target = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
      i_redirect_target[1:0] = 2'b00;
`endif
      i_pc_en    = ($urandom_range(99) < 85);
      i_if_id_en = ($urandom_range(99) < 85);
      tick();
      if (pre_rst) begin
        n_tests++;
        if (o_imem_req !== 1'b0 || o_if_id_valid !== 1'b0 || o_if_id_inst !== NOP_INST ||
            o_if_id_pc !== 32'h0 || o_imem_addr !== RESET_ADDR) begin
          n_fail++;
          $display("FAIL rnd_reset @%0d: got req=%b v=%b inst=%h pc=%h addr=%h", cyc,
                   o_imem_req, o_if_id_valid, o_if_id_inst, o_if_id_pc, o_imem_addr);
        end
        exp_next_pc = RESET_ADDR;
      end else begin
        if (pre_req && pre_ready) begin
          n_tests++;
          if (pre_addr !== exp_next_pc) begin
            n_fail++;
            $display("FAIL rnd_req_addr @%0d: got %h expected %h", cyc, pre_addr, exp_next_pc);
          end
          n_tests++;
          if (o_imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd_one_outstanding @%0d: got req=%b expected 0", cyc, o_imem_req);
          end
        end else if (pre_req && !pre_redirect) begin
          n_tests++;
          if (o_imem_req !== 1'b1 || o_imem_addr !== pre_addr) begin
            n_fail++;
            $display("FAIL rnd_req_stable @%0d: got req=%b addr=%h expected 1 %h",
                     cyc, o_imem_req, o_imem_addr, pre_addr);
          end
        end
        if (pre_redirect) begin
          n_tests++;
          if (o_if_id_valid !== 1'b0 || o_if_id_inst !== NOP_INST) begin
            n_fail++;
            $display("FAIL rnd_flush @%0d: got v=%b inst=%h expected 0 %h",
                     cyc, o_if_id_valid, o_if_id_inst, NOP_INST);
          end
          exp_next_pc = {pre_target[31:2], 2'b00};
        end else if (!pre_if_id_en) begin
          n_tests++;
          if (o_if_id_valid !== pre_if_id_valid || o_if_id_pc !== pre_if_id_pc ||
              o_if_id_pc_plus4 !== pre_if_id_plus4 || o_if_id_inst !== pre_if_id_inst) begin
            n_fail++;
            $display("FAIL rnd_stall_hold @%0d: got v=%b pc=%h inst=%h expected v=%b pc=%h inst=%h", cyc,
                     o_if_id_valid, o_if_id_pc, o_if_id_inst, pre_if_id_valid, pre_if_id_pc, pre_if_id_inst);
          end
        end else if (o_if_id_valid === 1'b1) begin
          n_tests++;
          if (!pre_pc_en || o_if_id_pc !== exp_next_pc || o_if_id_inst !== mem_word(exp_next_pc) ||
              o_if_id_pc_plus4 !== exp_next_pc + 32'd4) begin
            n_fail++;
            $display("FAIL rnd_load @%0d: got pc_en=%b pc=%h inst=%h p4=%h expected 1 %h %h %h", cyc,
                     pre_pc_en, o_if_id_pc, o_if_id_inst, o_if_id_pc_plus4,
                     exp_next_pc, mem_word(exp_next_pc), exp_next_pc + 32'd4);
          end
          exp_next_pc = exp_next_pc + 32'd4;
          loads++;
        end else begin
          n_tests++;
          if (o_if_id_inst !== NOP_INST || o_if_id_pc !== pre_if_id_pc ||
              o_if_id_pc_plus4 !== pre_if_id_plus4) begin
            n_fail++;
            $display("FAIL rnd_bubble @%0d: got inst=%h pc=%h p4=%h expected %h %h %h", cyc,
                     o_if_id_inst, o_if_id_pc, o_if_id_pc_plus4, NOP_INST, pre_if_id_pc, pre_if_id_plus4);
          end
        end
      end
    end
    i_rst = 1'b0;  i_redirect = 1'b0;
    n_tests++;
    if (loads < 100) begin
      n_fail++;
      $display("FAIL rnd_progress: got %0d loads expected at least 100", loads);
    end
  endtask

  initial begin
    i_rst = 1'b1;  i_pc_en = 1'b1;  i_if_id_en = 1'b1;  i_redirect = 1'b0;
    i_redirect_target = 32'h0;  i_imem_ready = 1'b0;  i_imem_valid = 1'b0;  i_imem_rdata = 32'h0;
    exp_next_pc = RESET_ADDR;
    mem_ovr[32'h0] = 32'h0050_0093;
    mem_ovr[32'h4] = 32'h00a0_0113;
    mem_ovr[32'h8] = 32'h0000_0033;
    test_reset();
    test_zero_wait();
    test_ready_stall();
    test_hold();
    test_redirect_wait();
    test_redirect_flush();
    test_wrap();
    test_misalign();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
